// File: rtl/nvram_upload_responder.sv
// ---------------------------------------------------------------------------
// nvram_upload_responder
//
// Serves HPS NVRAM/hiscore uploads (core -> SD card). When an upload for
// UPLOAD_INDEX starts, the block first pauses the game CPU. It then waits for
// the pause to settle. After that it answers each one-cycle ioctl_rd strobe
// by reading one byte from a window of game RAM. The byte is returned on
// ioctl_din, and ioctl_wait is held high until that byte is valid.
//
// Ports:
//   clk_sys       in   system clock
//   reset         in   synchronous, active-high reset
//   ioctl_upload  in   HPS upload in progress
//   ioctl_index   in   upload target index
//   ioctl_rd      in   one-cycle byte read strobe from HPS
//   ioctl_addr    in   byte offset of the current read
//   ioctl_din     out  byte returned to HPS
//   ioctl_wait    out  high while ioctl_din is not yet valid
//   pause_req     out  request to halt the game CPU
//   paused        in   CPU-halted acknowledge
//   ram_addr      out  game RAM read address
//   ram_rd        out  one-cycle game RAM read enable
//   ram_data      in   game RAM read data (valid RAM_LAT cycles after ram_rd)
//   active        out  high whenever the block is not idle
// ---------------------------------------------------------------------------
module nvram_upload_responder #(
  parameter int unsigned              ADDR_W       = 16,
  parameter logic [ADDR_W-1:0]        BASE         = 16'h8000,
  parameter int unsigned              LEN          = 1024,
  parameter logic [7:0]               UPLOAD_INDEX = 8'd4,
  parameter int unsigned              RAM_LAT      = 1,
  parameter int unsigned              SETTLE       = 4
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_upload,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_rd,
  input  logic [24:0]       ioctl_addr,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_wait,
  output logic              pause_req,
  input  logic              paused,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rd,
  input  logic [7:0]        ram_data,
  output logic              active
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PAUSE_WAIT,
    S_READY,
    S_READ,
    S_ZERO
  } state_t;

  localparam logic [24:0] LEN_W    = 25'(LEN);
  localparam logic [4:0]  SETTLE_W = 5'(SETTLE);
  localparam logic [2:0]  LAT_W    = 3'(RAM_LAT);

  state_t            state_q;
  logic              upload_prev_q;
  logic [3:0]        settle_q;
  logic [2:0]        lat_q;
  logic [7:0]        din_q;
  logic              wait_q;
  logic              pause_req_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic              ram_rd_q;
  logic              active_q;

  logic              upload_rise;
  logic              settle_done;
  logic [4:0]        settle_inc;

  assign upload_rise = ioctl_upload && !upload_prev_q;

  // The settle counter counts edges that see paused high. The wait is over
  // once SETTLE such edges have been seen, measured from the paused rise.
  // SETTLE=0 releases on the first edge that sees paused.
  assign settle_inc  = {1'b0, settle_q} + 5'd1;
  assign settle_done = (settle_inc >= SETTLE_W);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q       <= S_IDLE;
      upload_prev_q <= 1'b0;
      settle_q      <= '0;
      lat_q         <= '0;
      din_q         <= 8'h00;
      wait_q        <= 1'b0;
      pause_req_q   <= 1'b0;
      ram_addr_q    <= '0;
      ram_rd_q      <= 1'b0;
      active_q      <= 1'b0;
    end else begin
      upload_prev_q <= ioctl_upload;

      if (state_q != S_IDLE && !ioctl_upload) begin
        // Upload ended. This beats everything else, including a pending
        // strobe or a read completing on this edge. ioctl_din is kept.
        state_q     <= S_IDLE;
        pause_req_q <= 1'b0;
        ram_rd_q    <= 1'b0;
        wait_q      <= 1'b0;
        active_q    <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (upload_rise && ioctl_index == UPLOAD_INDEX) begin
              pause_req_q <= 1'b1;
              wait_q      <= 1'b1;
              active_q    <= 1'b1;
              settle_q    <= '0;
              state_q     <= S_PAUSE_WAIT;
            end
          end

          S_PAUSE_WAIT: begin
            if (!paused) begin
              settle_q <= '0;
            end else if (settle_done) begin
              wait_q  <= 1'b0;
              state_q <= S_READY;
            end else begin
              settle_q <= settle_q + 4'd1;
            end
          end

          S_READY: begin
            if (!paused) begin
              // The CPU resumed under us. Hold the HPS off until it is
              // halted and settled again.
              wait_q   <= 1'b1;
              settle_q <= '0;
              state_q  <= S_PAUSE_WAIT;
            end else if (ioctl_rd) begin
              wait_q <= 1'b1;
              if (ioctl_addr < LEN_W) begin
                ram_addr_q <= BASE + ioctl_addr[ADDR_W-1:0];
                ram_rd_q   <= 1'b1;
                lat_q      <= LAT_W;
                state_q    <= S_READ;
              end else begin
                din_q   <= 8'h00;
                state_q <= S_ZERO;
              end
            end
          end

          S_READ: begin
            ram_rd_q <= 1'b0;
            if (lat_q == 3'd0) begin
              din_q   <= ram_data;
              wait_q  <= 1'b0;
              state_q <= S_READY;
            end else begin
              lat_q <= lat_q - 3'd1;
            end
          end

          S_ZERO: begin
            wait_q  <= 1'b0;
            state_q <= S_READY;
          end

          default: begin
            state_q     <= S_IDLE;
            pause_req_q <= 1'b0;
            ram_rd_q    <= 1'b0;
            wait_q      <= 1'b0;
            active_q    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign ioctl_din  = din_q;
  assign ioctl_wait = wait_q;
  assign pause_req  = pause_req_q;
  assign ram_addr   = ram_addr_q;
  assign ram_rd     = ram_rd_q;
  assign active     = active_q;

endmodule

// File: doc/nvram_upload_responder.md
Name: nvram_upload_responder

Overview:
- Serves the HPS side of an NVRAM/hiscore upload (save to SD card). It is the read-out counterpart of the ioctl download path that writes ROM and DIP data into the core.
- When the HPS starts an upload for this block's index, the block pauses the game CPU. It then answers each HPS byte-read strobe by fetching the byte from a window of game RAM through a dedicated read port, and returns it on ioctl_din with a wait handshake.
- It sits beside hps_io in the emu top level, between hps_io, the pause module and the game RAM arbitration port.

Parameters:
- ADDR_W, 16, width of the game RAM address port.
- BASE, 16'h8000, game RAM address that maps to upload offset 0.
- LEN, 1024, number of bytes in the window; offsets at or above LEN read as 8'h00.
- UPLOAD_INDEX, 8'd4, ioctl_index value this block responds to.
- RAM_LAT, 1, game RAM read latency in cycles, measured from the ram_rd cycle to data valid. Legal range 1..7.
- SETTLE, 4, cycles to wait after paused rises before serving reads. Legal range 0..15.

Ports:
- clk_sys  in  1  system clock (CLK_49M domain).
- reset  in  1  synchronous, active-high reset.
- ioctl_upload  in  1  HPS upload in progress.
- ioctl_index  in  8  upload target index.
- ioctl_rd  in  1  one-cycle byte read strobe from HPS.
- ioctl_addr  in  25  byte offset of the current read.
- ioctl_din  out  8  byte returned to HPS.
- ioctl_wait  out  1  high while ioctl_din is not yet valid; HPS must not strobe while it is high.
- pause_req  out  1  request to the pause module to halt the CPU.
- paused  in  1  CPU-halted acknowledge.
- ram_addr  out  ADDR_W  game RAM read address.
- ram_rd  out  1  one-cycle RAM read enable.
- ram_data  in  8  game RAM read data.
- active  out  1  high in every state except IDLE.

Behaviour:
- Reset values: ioctl_din=8'h00, ioctl_wait=0, pause_req=0, ram_addr=0, ram_rd=0, active=0, state=IDLE.
- State machine:
  - IDLE:
    - Entry condition: rising edge of ioctl_upload (registered previous value) with ioctl_index==UPLOAD_INDEX.
    - On entry: pause_req<=1, ioctl_wait<=1, active<=1, go to PAUSE_WAIT.
    - A rising edge with any other index leaves the block in IDLE; all outputs stay idle.
  - PAUSE_WAIT:
    - Hold until paused==1, then count SETTLE cycles. If paused drops during the count, the count restarts.
    - At count end: ioctl_wait<=0, go to READY.
  - READY:
    - On the edge where ioctl_rd==1, latch the offset.
    - If offset<LEN: ram_addr<=BASE+offset[ADDR_W-1:0] (truncating add), ram_rd<=1, ioctl_wait<=1, cnt<=RAM_LAT, go to READ.
    - If offset>=LEN: ioctl_din<=8'h00, ioctl_wait<=1, go to ZERO.
    - If paused drops while in READY: ioctl_wait<=1, go to PAUSE_WAIT.
  - READ:
    - ram_rd<=0 on the first edge; cnt decrements each cycle.
    - When cnt reaches 0: ioctl_din<=ram_data, ioctl_wait<=0, go to READY.
    - Net timing: ioctl_din is updated and ioctl_wait falls on edge T+1+RAM_LAT, where T is the ioctl_rd sample edge.
  - ZERO: ioctl_wait<=0 and go to READY one edge after entry.
- Overriding rules:
  - Upload end: a falling ioctl_upload in any non-IDLE state goes to IDLE on the next edge, and all of the following take effect on that edge:
    - pause_req<=0, ram_rd<=0, ioctl_wait<=0, active<=0;
    - an in-flight read is abandoned and ioctl_din keeps its last value.
  - A falling ioctl_upload has priority over an ioctl_rd on the same edge.
  - ioctl_rd outside READY is ignored, with no side effect.
  - ram_rd is never high for more than one consecutive cycle, and never high outside READ entry.
  - pause_req stays continuously high from IDLE exit until return to IDLE.
  - Reset mid-operation returns all outputs to their reset values on that edge, including pause_req=0.

Test Plan:
- Upload start, index 4, paused tied to pause_req with 3-cycle delay, SETTLE=4 -> pause_req rises 1 edge after the upload rise; ioctl_wait stays high until 4 cycles after paused rises, then falls.
- READY, RAM holds 8'hA5 at 16'h8010, ioctl_rd with addr 16, RAM_LAT=1 -> ram_addr=16'h8010 with ram_rd high for exactly 1 cycle; ioctl_din=8'hA5 and ioctl_wait=0 at edge T+2.
- RAM_LAT=3, same read -> ioctl_wait high for exactly 4 cycles; ioctl_din is updated at edge T+4.
- ioctl_rd with addr 1024 (LEN=1024) -> ram_rd stays 0; ioctl_din=8'h00; ioctl_wait high for exactly 1 cycle.
- ioctl_upload drops during READ (RAM_LAT=3, 1 cycle after strobe) -> on the next edge: IDLE, pause_req=0, ioctl_wait=0, active=0, ioctl_din unchanged from the previous byte.
- Upload rise with ioctl_index=8'd1 -> pause_req, active and ioctl_wait remain 0; ioctl_rd pulses produce no ram_rd.
